// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the instruction cache.
package icache_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Number of word-offset bits inside a block (0 for single-word blocks).
  function automatic int woff_bits(input int words);
    return $clog2(words);
  endfunction

  // Number of set-index bits.
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag width: what remains of a 32-bit byte address after the byte offset,
  // word offset and index fields are removed.
  function automatic int tag_bits(input int sets, input int words);
    return 32 - 2 - idx_bits(sets) - woff_bits(words);
  endfunction

  // Physical width for a field that may be logically zero bits wide.
  function automatic int field_w(input int bits);
    return (bits > 0) ? bits : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag store and block data with a combinational
// lookup port and a single word-write port used by the block fill.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 2,
  localparam int IDX_W  = idx_bits(SETS),
  localparam int WOFF_W = field_w(woff_bits(WORDS)),
  localparam int TAG_W  = tag_bits(SETS, WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inval,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [WOFF_W-1:0] rd_woff,
  output logic              rd_valid,
  output logic              rd_hit,
  output word_t             rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_woff,
  input  word_t             wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag
);
  localparam int AW = $clog2(SETS * WORDS);

  logic [SETS-1:0]  valid_reg;
  logic [TAG_W-1:0] tag_mem  [SETS];
  word_t            data_mem [SETS*WORDS];

  // Flattened data address: index in the high bits, word offset in the low bits.
  function automatic logic [AW-1:0] flat_addr(input logic [IDX_W-1:0] idx,
                                              input logic [WOFF_W-1:0] woff);
    return (WORDS == 1) ? AW'(idx) : AW'({idx, woff});
  endfunction

  // Valid bits: cleared by reset or invalidate (invalidate wins over a tag write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (inval) begin
      valid_reg <= '0;
    end else if (tag_we) begin
      valid_reg[wr_idx] <= 1'b1;
    end
  end

  // Tag store, written once when a block fill completes.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[wr_idx] <= wr_tag;
    end
  end

  // Block data, written one word per accepted fill beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[flat_addr(wr_idx, wr_woff)] <= wr_data;
    end
  end

  // Hits are combinational, so the lookup reads the arrays asynchronously.
  assign rd_valid = valid_reg[rd_idx];
  assign rd_hit   = rd_valid && (tag_mem[rd_idx] == rd_tag);
  assign rd_data  = data_mem[flat_addr(rd_idx, rd_woff)];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative (1 or 2 way) read-only instruction cache with true LRU,
// multi-word blocks, synchronous invalidate and a block-fill FSM.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int CPUID = 0,
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  input  logic  iinval,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);
  localparam int WOFF   = woff_bits(WORDS);
  localparam int WOFF_W = field_w(WOFF);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(SETS, WORDS);
  localparam logic [WOFF_W-1:0] LAST_WORD = WOFF_W'(WORDS - 1);
  // The channel index is only meaningful to the wrapper that routes the ports.
  localparam int unused_cpuid = CPUID;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic              unused_byte_off;

  icache_state_t     state_reg, state_next;
  logic [WOFF_W-1:0] cnt_reg, cnt_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              victim_reg, victim_next;

  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_hit;
  word_t             way_data [WAYS];

  logic  hit_any;
  logic  hit_way;
  logic  victim_sel;
  logic  lru_victim;
  logic  lru_hit;
  logic  fill_we;
  logic  fill_done;
  word_t fill_addr;

  // Request address split; the byte offset is ignored.
  assign req_tag         = imemaddr[31 -: TAG_W];
  assign req_idx         = imemaddr[2+WOFF +: IDX_W];
  assign unused_byte_off = ^imemaddr[1:0];

  generate
    if (WOFF > 0) begin : g_woff
      assign req_woff  = imemaddr[2 +: WOFF_W];
      assign fill_addr = {tag_reg, idx_reg, cnt_reg, 2'b00};
    end else begin : g_no_woff
      assign req_woff  = '0;
      assign fill_addr = {tag_reg, idx_reg, 2'b00};
    end
  endgenerate

  // One storage way per associativity level; only the victim way takes fill writes.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      icache_way #(
        .SETS (SETS),
        .WORDS(WORDS)
      ) u_way (
        .clk     (CLK),
        .rst_n   (nRST),
        .inval   (iinval),
        .rd_idx  (req_idx),
        .rd_tag  (req_tag),
        .rd_woff (req_woff),
        .rd_valid(way_valid[gi]),
        .rd_hit  (way_hit[gi]),
        .rd_data (way_data[gi]),
        .wr_en   (fill_we && (victim_reg == 1'(gi))),
        .wr_idx  (idx_reg),
        .wr_woff (cnt_reg),
        .wr_data (iload),
        .tag_we  (fill_done && (victim_reg == 1'(gi))),
        .wr_tag  (tag_reg)
      );
    end
  endgenerate

  // Select the hitting way's word; a tag never lives in two ways of one set.
  always_comb begin
    hit_way  = 1'b0;
    imemload = way_data[0];
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way  = 1'(w);
        imemload = way_data[w];
      end
    end
  end

  assign hit_any = |way_hit;

  // Victim: lowest-numbered invalid way, otherwise the LRU way of the set.
  always_comb begin
    victim_sel = lru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_sel = 1'(w);
      end
    end
  end

  generate
    if (WAYS == 2) begin : g_lru
      logic [SETS-1:0] lru_reg;

      // LRU bit names the next victim: point it away from the way just used.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          lru_reg <= '0;
        end else if (iinval) begin
          lru_reg <= '0;
        end else if (fill_done) begin
          lru_reg[idx_reg] <= ~victim_reg;
        end else if (lru_hit) begin
          lru_reg[req_idx] <= ~hit_way;
        end
      end

      assign lru_victim = lru_reg[req_idx];
    end else begin : g_no_lru
      logic unused_lru_inputs;
      assign lru_victim        = 1'b0;
      assign unused_lru_inputs = hit_way ^ lru_hit;
    end
  endgenerate

  // FSM state and fill bookkeeping registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      tag_reg    <= '0;
      idx_reg    <= '0;
      victim_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tag_reg    <= tag_next;
      idx_reg    <= idx_next;
      victim_reg <= victim_next;
    end
  end

  // Next-state and output decode: hits served in IDLE, block fetched in FILL.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    tag_next    = tag_reg;
    idx_next    = idx_reg;
    victim_next = victim_reg;
    ihit        = 1'b0;
    lru_hit     = 1'b0;
    iREN        = 1'b0;
    iaddr       = '0;
    fill_we     = 1'b0;
    fill_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        ihit    = imemREN && hit_any;
        lru_hit = ihit;
        if (imemREN && !hit_any) begin
          state_next  = FILL;
          tag_next    = req_tag;
          idx_next    = req_idx;
          victim_next = victim_sel;
          cnt_next    = '0;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = fill_addr;
        if (iinval) begin
          // Abort: nothing of the partial block becomes valid.
          state_next = IDLE;
          cnt_next   = '0;
        end else if (!iwait) begin
          fill_we = 1'b1;
          if (cnt_reg == LAST_WORD) begin
            fill_done  = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + WOFF_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Randomised scoreboard bench for icache_assoc: a 2-way/2-word and a
// 1-way/4-word instance, each checked against a timestamp-LRU cache model.
`timescale 1ns/1ps
module tb_icache_assoc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Backing memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int W    = (gi == 0) ? 2 : 1;
    localparam int S    = 8;
    localparam int N    = (gi == 0) ? 2 : 4;
    localparam int OFFB = 2 + $clog2(N);

    logic        nrst, imemren, ihit, iinval, iren, iwait;
    logic [31:0] imemaddr, imemload, iaddr, iload;

    icache_assoc #(
      .CPUID(gi),
      .WAYS (W),
      .SETS (S),
      .WORDS(N)
    ) u_dut (
      .CLK     (clk),
      .nRST    (nrst),
      .imemREN (imemren),
      .imemaddr(imemaddr),
      .ihit    (ihit),
      .imemload(imemload),
      .iinval  (iinval),
      .iREN    (iren),
      .iaddr   (iaddr),
      .iwait   (iwait),
      .iload   (iload)
    );

    assign iload = mem_word(iaddr);

    int          wait_mode = 0;   // 0 no stalls, 1 random stalls, 2 three stalls per word
    logic [31:0] fillq [$];
    logic [31:0] dataq [$];
    bit          done_g = 1'b0;

    // Reference model: per way/set a valid flag, block number and last-use time.
    bit          m_valid [W][S];
    int unsigned m_blk   [W][S];
    int unsigned m_used  [W][S];
    int unsigned tick = 0;

    function automatic int unsigned blk_of(input logic [31:0] a);
      return a >> OFFB;
    endfunction

    task automatic model_clear();
      for (int w = 0; w < W; w++)
        for (int s = 0; s < S; s++)
          m_valid[w][s] = 1'b0;
    endtask

    function automatic int model_lookup(input logic [31:0] a);
      int s;
      s = int'(blk_of(a) % S);
      for (int w = 0; w < W; w++)
        if (m_valid[w][s] && m_blk[w][s] == blk_of(a)) return w;
      return -1;
    endfunction

    function automatic int model_victim(input logic [31:0] a);
      int s, v;
      s = int'(blk_of(a) % S);
      for (int w = 0; w < W; w++)
        if (!m_valid[w][s]) return w;
      v = 0;
      for (int w = 1; w < W; w++)
        if (m_used[w][s] < m_used[v][s]) v = w;
      return v;
    endfunction

    task automatic model_install(input int w, input logic [31:0] a);
      int s;
      s = int'(blk_of(a) % S);
      tick++;
      m_valid[w][s] = 1'b1;
      m_blk[w][s]   = blk_of(a);
      m_used[w][s]  = tick;
    endtask

    function automatic logic [31:0] block_base(input logic [31:0] a);
      return a & ~(32'(N * 4) - 32'd1);
    endfunction

    function automatic logic [31:0] dir_addr(input int i);
      if (W == 2) begin
        case (i)
          0: return 32'h040;  1: return 32'h044;  2: return 32'h088;  3: return 32'h240;
          4: return 32'h040;  5: return 32'h440;  6: return 32'h040;  default: return 32'h240;
        endcase
      end else begin
        case (i)
          0: return 32'h000;  1: return 32'h080;  2: return 32'h188;  3: return 32'h000;
          4: return 32'h080;  5: return 32'h084;  6: return 32'h000;  default: return 32'h004;
        endcase
      end
    endfunction

    // Controller stall generator.
    initial begin
      int pc;
      pc    = 0;
      iwait = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (wait_mode == 1) begin
          iwait = ($urandom_range(0, 2) == 0);
        end else if (wait_mode == 2 && iren) begin
          iwait = (pc < 3);
          pc    = (pc == 3) ? 0 : pc + 1;
        end else begin
          iwait = 1'b0;
          pc    = 0;
        end
      end
    end

    // Monitor: checks every fill request address and every delivered word.
    initial begin
      forever begin
        @(negedge clk);
        if (nrst) begin
          if (iren) begin
            if (fillq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL cfg%0d_unexpected_iREN: iaddr=0x%08h, required no request", gi, iaddr);
            end else begin
              check($sformatf("cfg%0d_fill_iaddr", gi), iaddr, fillq[0]);
              if (!iwait) void'(fillq.pop_front());
            end
          end
          if (ihit && imemren) begin
            if (dataq.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL cfg%0d_unexpected_ihit: addr=0x%08h, required no hit", gi, imemaddr);
            end else begin
              check($sformatf("cfg%0d_imemload", gi), imemload, dataq.pop_front());
            end
          end
        end
      end
    end

    task automatic wait_hit(output int cyc);
      cyc = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (iren) cyc++;
        if (ihit) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL cfg%0d_hit_timeout: addr=0x%08h, no ihit within 300 cycles", gi, imemaddr);
      fillq.delete();
      dataq.delete();
    endtask

    // Issue one read; expectations are queued before the request is raised.
    task automatic do_read(input logic [31:0] a);
      int w, cyc, exp_cyc;
      bit was_hit;
      logic [31:0] base;
      base = block_base(a);
      w    = model_lookup(a);
      dataq.push_back(mem_word({a[31:2], 2'b00}));
      if (w >= 0) begin
        was_hit = 1'b1;
        tick++;
        m_used[w][int'(blk_of(a) % S)] = tick;
        exp_cyc = 0;
      end else begin
        was_hit = 1'b0;
        for (int i = 0; i < N; i++) fillq.push_back(base + 32'(4 * i));
        model_install(model_victim(a), a);
        exp_cyc = (wait_mode == 2) ? 4 * N : N;
      end
      imemaddr = a;
      imemren  = 1'b1;
      wait_hit(cyc);
      if (wait_mode != 1 || exp_cyc == 0)
        check($sformatf("cfg%0d_fill_cycles@%08h", gi, a), 32'(cyc), 32'(exp_cyc));
      check($sformatf("cfg%0d_fill_drained", gi), 32'(fillq.size()), 32'd0);
      $display("cfg%0d read 0x%08h expected %s, fill cycles %0d", gi, a, was_hit ? "hit" : "miss", cyc);
      @(posedge clk);
      #1;
      imemren = 1'b0;
    endtask

    // Miss on a cold address, invalidate during the second fill word, then refill.
    task automatic read_inval(input logic [31:0] a);
      int cyc;
      logic [31:0] base;
      base = block_base(a);
      dataq.push_back(mem_word({a[31:2], 2'b00}));
      fillq.push_back(base);
      fillq.push_back(base + 32'd4);
      for (int i = 0; i < N; i++) fillq.push_back(base + 32'(4 * i));
      model_clear();
      model_install(model_victim(a), a);
      imemaddr = a;
      imemren  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      iinval = 1'b1;
      @(posedge clk);
      #1;
      iinval = 1'b0;
      wait_hit(cyc);
      check($sformatf("cfg%0d_refill_cycles", gi), 32'(cyc), 32'(N));
      check($sformatf("cfg%0d_refill_drained", gi), 32'(fillq.size()), 32'd0);
      $display("cfg%0d read 0x%08h with invalidate mid-fill, refill cycles %0d", gi, a, cyc);
      @(posedge clk);
      #1;
      imemren = 1'b0;
    endtask

    task automatic inval_idle();
      iinval = 1'b1;
      @(posedge clk);
      #1;
      iinval = 1'b0;
      model_clear();
      $display("cfg%0d invalidate all", gi);
    endtask

    // Start a fill and pull reset during its second word.
    task automatic reset_mid_fill(input logic [31:0] a);
      fillq.push_back(block_base(a));
      imemaddr = a;
      imemren  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      nrst    = 1'b0;
      imemren = 1'b0;
      #1;
      check($sformatf("cfg%0d_rst_iREN", gi), 32'(iren), 32'd0);
      check($sformatf("cfg%0d_rst_iaddr", gi), iaddr, 32'd0);
      check($sformatf("cfg%0d_rst_ihit", gi), 32'(ihit), 32'd0);
      check($sformatf("cfg%0d_rst_drained", gi), 32'(fillq.size()), 32'd0);
      model_clear();
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      $display("cfg%0d reset pulsed during fill of 0x%08h", gi, a);
    endtask

    // Stimulus: reset, directed sequence, invalidate/reset cases, random reads.
    initial begin
      logic [31:0] a;
      nrst     = 1'b0;
      imemren  = 1'b0;
      iinval   = 1'b0;
      imemaddr = '0;
      model_clear();
      #2;
      check($sformatf("cfg%0d_reset_iREN", gi), 32'(iren), 32'd0);
      check($sformatf("cfg%0d_reset_iaddr", gi), iaddr, 32'd0);
      check($sformatf("cfg%0d_reset_ihit", gi), 32'(ihit), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        wait_mode = (i == 2) ? 2 : 0;
        do_read(dir_addr(i));
      end
      wait_mode = 0;
      read_inval(32'h1100);
      inval_idle();
      do_read(32'h1100);
      do_read(dir_addr(0));
      reset_mid_fill(32'h2300);
      do_read(32'h2300);
      do_read(32'h2300);
      wait_mode = 1;
      for (int t = 0; t < 150; t++) begin
        a = (32'($urandom_range(0, 3)) << (OFFB + 3)) |
            (32'($urandom_range(0, S - 1)) << OFFB) |
            (32'($urandom_range(0, N - 1)) << 2) |
            32'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) inval_idle();
        do_read(a);
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      wait_mode = 0;
      repeat (2) @(posedge clk);
      done_g = 1'b1;
    end
  end

  // Completion wait with an overall time limit, then the summary.
  initial begin
    for (int t = 0; t < 20000; t++) begin
      if (g_cfg[0].done_g && g_cfg[1].done_g) break;
      #10;
    end
    if (!(g_cfg[0].done_g && g_cfg[1].done_g)) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: stimulus done flags %0b%0b, required 11", g_cfg[1].done_g, g_cfg[0].done_g);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised, read-only instruction cache for one CPU: set-associative (1 or 2 ways), configurable set count and words per block, with a multi-word block-fill state machine toward the memory controller. It sits inside the per-CPU `caches` wrapper in place of the fixed direct-mapped icache and connects between the datapath's instruction port and the controller's per-CPU instruction channel (index `CPUID`). It adds true LRU replacement, multi-word blocks and a synchronous invalidate.

## Interface
Parameters:
- `CPUID`, 0: controller channel index this cache drives.
- `WAYS`, 2: associativity, legal values 1 or 2.
- `SETS`, 8: sets per way, power of two, 2 to 64.
- `WORDS`, 2: 32-bit words per block, power of two, 1 to 8.

Ports:
- `CLK` in 1: clock. One clock; reset is asynchronous and active-low.
- `nRST` in 1: asynchronous active-low reset.
- `imemREN` in 1: datapath instruction read request.
- `imemaddr` in 32: byte address, bits [1:0] ignored.
- `ihit` out 1: instruction valid this cycle.
- `imemload` out 32: instruction word.
- `iinval` in 1: invalidate all blocks (self-modifying code / halt).
- `iREN` out 1: controller read request (`ccif.iREN[CPUID]`).
- `iaddr` out 32: controller word address, bits [1:0] always 0.
- `iwait` in 1: controller stall; the word is valid when low while `iREN` is high.
- `iload` in 32: controller read data.

## Operation
- Address split, LSB first:
  - 2-bit byte offset.
  - `WOFF = log2(WORDS)` word offset.
  - `IDX = log2(SETS)` index.
  - The remaining bits are the tag.
- Per way per set: valid bit, tag, and `WORDS` data words. Per set: one LRU bit (present only when `WAYS=2`) naming the next victim.
- Hit: `imemREN` and some way at the index is valid with a matching tag. The cache then drives `ihit=1` and `imemload` from the hitting way's word. When `WAYS=2`, set LRU to the other way.
- FSM states:
  - IDLE → FILL on `imemREN` and miss. The block-aligned address (tag, index) is latched and the victim way is chosen as follows: the lowest-numbered invalid way, else the LRU way.
  - FILL:
    - Hold `iREN=1` with `iaddr` = {latched tag, index, word counter, 2'b00}.
    - Each cycle with `iwait=0`, write `iload` into the victim word at the counter position and increment the counter.
    - After the word at `WORDS-1` is written, write the tag, set valid, set LRU to the other way, clear the counter and return to IDLE.
- During FILL, `ihit=0` and changes on `imemaddr` and `imemREN` are ignored; the fill always completes for the latched block.
- The first fill word is not forwarded, so the datapath re-hits in IDLE.
- `iinval`:
  - Clears all valid bits and LRU bits on the next edge.
  - In FILL, it aborts the fill: counter cleared, return to IDLE, no valid bit set.
  - `iinval` has priority over a same-cycle fill completion and over a same-cycle hit's LRU update. `ihit` is still reported combinationally that cycle.
- `WAYS=1`: no LRU storage, and way 0 is always the victim.

## Timing
- Hit: combinational, `ihit` in the same cycle as the request, zero added latency.
- Miss: the request cycle has `ihit=0`. FILL takes `WORDS` cycles plus the total `iwait` stall cycles. `ihit=1` arrives on the first IDLE cycle after the last word.
- `iREN` is registered-state-derived (high exactly in FILL) and glitch-free relative to `imemREN`.
- Reset values:
  - FSM in IDLE, counter 0, all valid and LRU bits 0.
  - `iREN=0`, `iaddr=0`, `ihit=0`.
  - `imemload` is don't-care but must be driven.
- Reset asserted mid-fill: immediate return to the reset state; the partial block stays invalid.
- Counter wrap at `WORDS-1` is the completion condition; the counter never indexes beyond the block.

## Structure
- Shared package `icache_pkg`:
  - `icache_state_t` enum {IDLE, FILL}.
  - Address-field width functions parameterised by `SETS` and `WORDS`.
  - The `word_t` typedef already used by the cpu types package.
- One natural sub-module, `icache_way`: per-way valid/tag/data arrays with a lookup-compare output and a word-write port. It is instantiated `WAYS` times via generate. The FSM and LRU logic stay in the top.

## Test plan
1. Cold miss, `WAYS=2`, `SETS=8`, `WORDS=2`, read 0x0000_0040 with `iwait=0` → `iREN` asserted for 2 cycles with `iaddr` 0x40 then 0x44; `ihit` high next cycle with the word from 0x40. A read of 0x44 then hits without `iREN`.
2. Stalled fill: `iwait=1` for 3 cycles per word → the fill lasts 8 cycles, `iaddr` is held stable during the stalls, and the data matches.
3. LRU eviction:
   - Fill 0x040 (way 0) and 0x240 (way 1), both index 0 (block 8 bytes, 8 sets: index bits [5:3]).
   - Re-hit 0x040, then read 0x440 → way 1 is evicted.
   - 0x040 still hits and 0x240 misses.
4. `iinval` during the second fill word → FSM returns to IDLE and a re-read of the same address misses again. `iinval` in IDLE makes every prior block miss.
5. `nRST` pulsed mid-fill → outputs reach reset values asynchronously, and a subsequent read of the same address performs a full fill.
6. `WAYS=1`, `WORDS=4`: conflicting addresses 0x000 and 0x080 → each alternately evicts the other, and each fill issues 4 sequential word addresses.
